// File: rtl/auto_fire_pkg.sv
// auto_fire_pkg: shared types and constants for the auto-fire controller.
//   fire_state_e        : controller state encoding, also exported on the
//                         controller's state port.
//   DEFAULT_CX/CY       : screen centre in pixels.
//   DEFAULT_LOCK_ZONE   : lock window half-width. The pixel mixer draws its
//                         lock window from the same constants.
//   in_lock_window()    : strict-bounds lock window test in 11-bit unsigned,
//                         so that CX+LOCK_ZONE above 1023 cannot wrap.
package auto_fire_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        FIRE     = 2'd2,
        COOLDOWN = 2'd3
    } fire_state_e;

    localparam int DEFAULT_CX        = 320;
    localparam int DEFAULT_CY        = 240;
    localparam int DEFAULT_LOCK_ZONE = 30;

    function automatic logic in_lock_window(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic       detected,
        input int         cx,
        input int         cy,
        input int         zone
    );
        logic [10:0] xe;
        logic [10:0] ye;
        xe = {1'b0, x};
        ye = {1'b0, y};
        return detected
            && (xe > 11'(cx - zone)) && (xe < 11'(cx + zone))
            && (ye > 11'(cy - zone)) && (ye < 11'(cy + zone));
    endfunction

endpackage

// File: rtl/auto_fire_ctrl_pulse_timer.sv
// pulse_timer: fixed-width pulse generator.
//   clk, reset : clock and synchronous active-high reset.
//   start      : begins a pulse. Ignored while a pulse is already running.
//   busy       : registered. High for exactly CYCLES cycles, starting on the
//                edge that samples start.
//   done       : one-cycle pulse on the last busy cycle. The edge that ends
//                that cycle is the edge on which busy falls.
module pulse_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    // Number of busy cycles still to come after the current one.
    logic [CW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            remaining <= '0;
        end else if (!busy) begin
            if (start) begin
                busy      <= 1'b1;
                remaining <= CW'(CYCLES - 1);
            end
        end else if (remaining == '0) begin
            busy <= 1'b0;
        end else begin
            remaining <= remaining - CW'(1);
        end
    end

    assign done = busy && (remaining == '0);

endmodule

// File: rtl/auto_fire_ctrl.sv
// auto_fire_ctrl: frame-synchronous trigger controller.
// It samples the tracker once per frame, qualifies a lock over consecutive
// in-zone frames, fires one fixed-width pulse, then waits out a cooldown.
//   clk, reset         : clock and synchronous active-high reset.
//   frame_start        : one-cycle pulse per frame. Samples are taken only then.
//   enable             : arm switch (level).
//   aim_x/aim_y        : tracker aim point.
//   aim_detected       : tracker valid flag.
//   lock_x/lock_y      : aim point latched at the last frame_start.
//   lock_valid         : aim_detected latched at the last frame_start.
//   locked             : the last sample was inside the lock window.
//   state              : current state (fire_state_e encoding).
//   fire               : registered trigger pulse, FIRE_CYCLES wide.
//   shot_count         : shots fired, saturating at 255.
module auto_fire_ctrl
    import auto_fire_pkg::*;
#(
    parameter int CX              = DEFAULT_CX,
    parameter int CY              = DEFAULT_CY,
    parameter int LOCK_ZONE       = DEFAULT_LOCK_ZONE,
    parameter int LOCK_FRAMES     = 4,
    parameter int LOST_FRAMES     = 3,
    parameter int FIRE_CYCLES     = 2500000,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       enable,
    input  logic [9:0] aim_x,
    input  logic [9:0] aim_y,
    input  logic       aim_detected,
    output logic [9:0] lock_x,
    output logic [9:0] lock_y,
    output logic       lock_valid,
    output logic       locked,
    output logic [1:0] state,
    output logic       fire,
    output logic [7:0] shot_count
);

    if (LOCK_ZONE > CX || LOCK_ZONE > CY) begin : g_bad_zone
        $error("auto_fire_ctrl: LOCK_ZONE must not exceed CX or CY");
    end
    if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || LOST_FRAMES < 1 || LOST_FRAMES > 15
        || COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255 || FIRE_CYCLES < 1) begin : g_bad_range
        $error("auto_fire_ctrl: frame/cycle parameter out of range");
    end

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_TRACK    = TRACK;
    localparam logic [1:0] ST_FIRE     = FIRE;
    localparam logic [1:0] ST_COOLDOWN = COOLDOWN;

    logic [3:0] hit_cnt;
    logic [3:0] miss_cnt;
    logic [7:0] cool_cnt;

    logic [1:0] state_n;
    logic [3:0] hit_n;
    logic [3:0] miss_n;
    logic [7:0] cool_n;
    logic [3:0] hit_adv;
    logic [3:0] miss_adv;
    logic       in_zone;
    logic       fire_start;
    logic       shot_inc;
    logic       timer_done;

    assign in_zone = in_lock_window(aim_x, aim_y, aim_detected, CX, CY, LOCK_ZONE);

    // Counter values that a frame sample would produce while tracking.
    assign hit_adv  = !in_zone ? 4'd0 :
                      (hit_cnt == 4'(LOCK_FRAMES)) ? hit_cnt : hit_cnt + 4'd1;
    assign miss_adv = aim_detected ? 4'd0 : miss_cnt + 4'd1;

    always_comb begin
        state_n    = state;
        hit_n      = hit_cnt;
        miss_n     = miss_cnt;
        cool_n     = cool_cnt;
        fire_start = 1'b0;
        shot_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                // The entry sample already counts toward the lock streak.
                if (frame_start && enable && aim_detected) begin
                    state_n = ST_TRACK;
                    hit_n   = 4'(in_zone);
                    miss_n  = 4'd0;
                end
            end
            ST_TRACK: begin
                // Disarm wins over a coincident sample; counters are not advanced.
                if (!enable) begin
                    state_n = ST_IDLE;
                    hit_n   = 4'd0;
                    miss_n  = 4'd0;
                end else if (frame_start) begin
                    hit_n  = hit_adv;
                    miss_n = miss_adv;
                    if (hit_adv == 4'(LOCK_FRAMES)) begin
                        state_n    = ST_FIRE;
                        fire_start = 1'b1;
                        hit_n      = 4'd0;
                        miss_n     = 4'd0;
                    end else if (miss_adv == 4'(LOST_FRAMES)) begin
                        state_n = ST_IDLE;
                        hit_n   = 4'd0;
                        miss_n  = 4'd0;
                    end
                end
            end
            ST_FIRE: begin
                // Only the pulse timer ends FIRE; samples and enable are ignored.
                if (timer_done) begin
                    state_n  = ST_COOLDOWN;
                    shot_inc = 1'b1;
                    cool_n   = 8'd0;
                    hit_n    = 4'd0;
                    miss_n   = 4'd0;
                end
            end
            ST_COOLDOWN: begin
                // Counters stay cleared so a re-fire needs a fresh streak.
                if (frame_start) begin
                    if (cool_cnt == 8'(COOLDOWN_FRAMES - 1)) begin
                        state_n = (enable && aim_detected) ? ST_TRACK : ST_IDLE;
                        cool_n  = 8'd0;
                    end else begin
                        cool_n = cool_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hit_cnt    <= 4'd0;
            miss_cnt   <= 4'd0;
            cool_cnt   <= 8'd0;
            shot_count <= 8'd0;
            lock_x     <= 10'd0;
            lock_y     <= 10'd0;
            lock_valid <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state    <= state_n;
            hit_cnt  <= hit_n;
            miss_cnt <= miss_n;
            cool_cnt <= cool_n;
            if (shot_inc && shot_count != 8'hFF) begin
                shot_count <= shot_count + 8'd1;
            end
            if (frame_start) begin
                lock_x     <= aim_x;
                lock_y     <= aim_y;
                lock_valid <= aim_detected;
                locked     <= in_zone;
            end
        end
    end

    // fire is the timer's registered busy flag, so it is high exactly
    // while the state register holds FIRE.
    pulse_timer #(
        .CYCLES (FIRE_CYCLES)
    ) u_fire_timer (
        .clk   (clk),
        .reset (reset),
        .start (fire_start),
        .busy  (fire),
        .done  (timer_done)
    );

endmodule

// File: tb/tb_auto_fire_ctrl.sv
// Testbench for auto_fire_ctrl with short timing parameters.
module tb_auto_fire_ctrl;

    localparam int CX = 320;
    localparam int CY = 240;
    localparam int LZ = 30;
    localparam int LF = 4;
    localparam int LOST = 3;
    localparam int FC = 8;
    localparam int CF = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       frame_start = 1'b0;
    logic       enable = 1'b1;
    logic [9:0] aim_x = 10'd0;
    logic [9:0] aim_y = 10'd0;
    logic       aim_detected = 1'b0;
    logic [9:0] lock_x;
    logic [9:0] lock_y;
    logic       lock_valid;
    logic       locked;
    logic [1:0] state;
    logic       fire;
    logic [7:0] shot_count;

    auto_fire_ctrl #(
        .CX(CX), .CY(CY), .LOCK_ZONE(LZ), .LOCK_FRAMES(LF), .LOST_FRAMES(LOST),
        .FIRE_CYCLES(FC), .COOLDOWN_FRAMES(CF)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .enable(enable),
        .aim_x(aim_x), .aim_y(aim_y), .aim_detected(aim_detected),
        .lock_x(lock_x), .lock_y(lock_y), .lock_valid(lock_valid), .locked(locked),
        .state(state), .fire(fire), .shot_count(shot_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 tracking, 2 firing, 3 cooling down
    int m_phase = 0;
    int m_lock_x = 0, m_lock_y = 0, m_lock_valid = 0, m_locked = 0;
    int m_shots = 0;
    int streak = 0, misses = 0, fire_left = 0, cool_seen = 0;
    bit armed = 0;

    function automatic int zone_hit(int x, int y, int det);
        return (det != 0 && x > CX - LZ && x < CX + LZ && y > CY - LZ && y < CY + LZ) ? 1 : 0;
    endfunction

    task automatic model_step();
        int iz;
        iz = zone_hit(int'(aim_x), int'(aim_y), int'(aim_detected));
        if (reset) begin
            m_phase = 0; m_lock_x = 0; m_lock_y = 0; m_lock_valid = 0; m_locked = 0;
            m_shots = 0; streak = 0; misses = 0; fire_left = 0; cool_seen = 0;
            return;
        end
        if (frame_start) begin
            m_lock_x = int'(aim_x); m_lock_y = int'(aim_y);
            m_lock_valid = int'(aim_detected); m_locked = iz;
        end
        case (m_phase)
            0: if (frame_start && enable && aim_detected) begin
                m_phase = 1; streak = iz; misses = 0;
            end
            1: if (!enable) begin
                m_phase = 0; streak = 0; misses = 0;
            end else if (frame_start) begin
                streak = iz ? ((streak + 1 > LF) ? LF : streak + 1) : 0;
                misses = aim_detected ? 0 : misses + 1;
                if (streak == LF) begin
                    m_phase = 2; fire_left = FC; streak = 0; misses = 0;
                end else if (misses == LOST) begin
                    m_phase = 0; streak = 0; misses = 0;
                end
            end
            2: begin
                fire_left--;
                if (fire_left == 0) begin
                    m_phase = 3; cool_seen = 0;
                    if (m_shots < 255) m_shots++;
                end
            end
            default: if (frame_start) begin
                cool_seen++;
                if (cool_seen == CF) m_phase = (enable && aim_detected) ? 1 : 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        armed = 1;
    end

    // Compare every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("lock_x", 32'(lock_x), 32'(m_lock_x));
            check("lock_y", 32'(lock_y), 32'(m_lock_y));
            check("lock_valid", 32'(lock_valid), 32'(m_lock_valid));
            check("locked", 32'(locked), 32'(m_locked));
            check("state", 32'(state), 32'(m_phase));
            check("fire", 32'(fire), (m_phase == 2) ? 32'd1 : 32'd0);
            check("shot_count", 32'(shot_count), 32'(m_shots));
        end
    end

    // Width of the most recent fire pulse.
    int run_len = 0;
    int last_len = 0;
    initial forever begin
        @(negedge clk);
        if (fire === 1'b1) run_len++;
        else if (run_len > 0) begin
            last_len = run_len;
            run_len = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame_start pulse; returns one cycle after it was sampled.
    task automatic frame(input int x, input int y, input bit det);
        @(negedge clk);
        #1;
        aim_x = 10'(x); aim_y = 10'(y); aim_detected = det; frame_start = 1'b1;
        @(negedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic frame_gap(input int x, input int y, input bit det);
        frame(x, y, det);
        gap(19);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_fire", 32'(fire), 32'd0);
        check("reset_shots", 32'(shot_count), 32'd0);
        #1 reset = 1'b0;

        // 1. lock and fire
        repeat (3) frame_gap(320, 240, 1);
        frame(320, 240, 1);
        check("t1_fire_state", 32'(state), 32'd2);
        check("t1_fire_high", 32'(fire), 32'd1);
        gap(19);
        check("t1_pulse_len", 32'(last_len), 32'd8);
        check("t1_shots", 32'(shot_count), 32'd1);
        check("t1_cooldown", 32'(state), 32'd3);
        check("t1_lock_x", 32'(lock_x), 32'd320);
        frame_gap(320, 240, 1);
        frame_gap(320, 240, 1);
        check("t1_back_track", 32'(state), 32'd1);

        // 2. streak broken by an out-of-zone sample
        do_reset();
        repeat (3) frame_gap(320, 240, 1);
        frame_gap(351, 240, 1);
        check("t2_out_zone_state", 32'(state), 32'd1);
        check("t2_out_zone_locked", 32'(locked), 32'd0);
        repeat (3) frame_gap(320, 240, 1);
        check("t2_no_fire_yet", 32'(fire), 32'd0);
        frame(320, 240, 1);
        check("t2_fires", 32'(fire), 32'd1);
        gap(19);

        // 3. strict window bounds
        do_reset();
        frame_gap(290, 240, 1); check("t3_x290", 32'(locked), 32'd0);
        frame_gap(350, 240, 1); check("t3_x350", 32'(locked), 32'd0);
        frame_gap(291, 240, 1); check("t3_x291", 32'(locked), 32'd1);
        frame_gap(349, 240, 1); check("t3_x349", 32'(locked), 32'd1);
        frame_gap(320, 210, 1); check("t3_y210", 32'(locked), 32'd0);
        frame_gap(320, 211, 1); check("t3_y211", 32'(locked), 32'd1);
        frame_gap(320, 240, 0); check("t3_nodet", 32'(locked), 32'd0);

        // 4. target lost
        do_reset();
        frame_gap(320, 240, 1);
        frame_gap(0, 0, 0);
        frame_gap(0, 0, 0);
        check("t4_two_misses", 32'(state), 32'd1);
        frame_gap(100, 100, 1);
        check("t4_redetect", 32'(state), 32'd1);
        frame_gap(0, 0, 0);
        frame_gap(0, 0, 0);
        frame(0, 0, 0);
        check("t4_lost", 32'(state), 32'd0);
        gap(19);

        // 5. enable dropped mid-fire, then in TRACK
        do_reset();
        repeat (3) frame_gap(320, 240, 1);
        frame(320, 240, 1);
        gap(2);
        #1 enable = 1'b0;
        gap(17);
        check("t5_pulse_len", 32'(last_len), 32'd8);
        check("t5_cooldown", 32'(state), 32'd3);
        frame_gap(320, 240, 1);
        frame(320, 240, 1);
        check("t5_idle_after_cool", 32'(state), 32'd0);
        gap(19);
        #1 enable = 1'b1;
        frame(320, 240, 1);
        check("t5_track", 32'(state), 32'd1);
        #1 enable = 1'b0;
        @(negedge clk);
        check("t5_disarm_idle", 32'(state), 32'd0);
        gap(18);

        // 6. reset on the third fire cycle (shot_count is 1 from test 5)
        #1 enable = 1'b1;
        repeat (3) frame_gap(320, 240, 1);
        frame(320, 240, 1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t6_fire", 32'(fire), 32'd0);
        check("t6_state", 32'(state), 32'd0);
        check("t6_shots", 32'(shot_count), 32'd0);
        check("t6_lock_x", 32'(lock_x), 32'd0);
        check("t6_lock_y", 32'(lock_y), 32'd0);
        #1 reset = 1'b0;
        gap(5);

        // Randomised frames against the model
        for (int i = 0; i < 80; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) do_reset();
            frame($urandom_range(285, 355), $urandom_range(205, 275),
                  $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 17);
                gap(k);
                #1 enable = ~enable;
                gap(19 - k);
            end else begin
                gap(19);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
